// File: rtl/shapool_host_link.sv
// shapool_host_link: host-side job shifter and daisy-chain result reader for one shapool chain.
module shapool_host_link #(
    parameter int JOB_BITS   = 352,
    parameter int DAISY_BITS = 64,
    parameter int SCK_DIV    = 4
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic [JOB_BITS-1:0]   job_data_in,
    input  logic                  job_valid_in,
    output logic                  job_ready_out,
    input  logic                  abort_in,
    output logic                  sck0_out,
    output logic                  sdo0_out,
    output logic                  cs0_n_out,
    output logic                  sck1_out,
    output logic                  sdo1_out,
    input  logic                  sdi1_in,
    output logic                  cs1_n_out,
    input  logic                  ready_n_in,
    output logic [DAISY_BITS-1:0] result_data_out,
    output logic                  result_valid_out,
    output logic                  busy_out
);
    localparam int BW = $clog2((JOB_BITS > DAISY_BITS ? JOB_BITS : DAISY_BITS) + 1);
    typedef enum logic [2:0] {
        IDLE, JOB_SETUP, JOB_SHIFT, JOB_HOLD, WAIT_READY, RD_SETUP, RD_SHIFT, RD_HOLD
    } state_t;
    state_t state, state_d;
    logic [7:0] div, div_d;
    logic [BW-1:0] bits, bits_d;
    logic sck, sck_d, last, valid_d;
    logic [JOB_BITS-1:0] sr, sr_d;
    logic [DAISY_BITS-1:0] cap, cap_d, res_d;
    logic [1:0] rdy_sync;
    assign last = div == 8'(SCK_DIV - 1);
    assign sdo1_out = 1'b0;
    always_comb begin
        state_d = state;
        div_d   = div + 8'd1;
        bits_d  = bits;
        sck_d   = sck;
        sr_d    = sr;
        cap_d   = cap;
        res_d   = result_data_out;
        valid_d = 1'b0;
        case (state)
            IDLE: begin
                div_d = '0;
                if (job_valid_in && job_ready_out) begin
                    sr_d    = job_data_in;
                    bits_d  = '0;
                    state_d = JOB_SETUP;
                end
            end
            JOB_SETUP, RD_SETUP: if (last) begin
                div_d   = '0;
                sck_d   = 1'b1;
                state_d = state == JOB_SETUP ? JOB_SHIFT : RD_SHIFT;
                cap_d   = state == RD_SETUP ? {cap[DAISY_BITS-2:0], sdi1_in} : cap;
            end
            JOB_SHIFT, RD_SHIFT: if (last) begin
                div_d = '0;
                if (sck) begin
                    sck_d  = 1'b0;
                    bits_d = bits + BW'(1);
                    sr_d   = state == JOB_SHIFT ? sr << 1 : sr;
                end else if (bits == (state == JOB_SHIFT ? BW'(JOB_BITS) : BW'(DAISY_BITS))) begin
                    state_d = state == JOB_SHIFT ? JOB_HOLD : RD_HOLD;
                end else begin
                    // host samples sdi1 on the same edge that raises sck1
                    sck_d = 1'b1;
                    cap_d = state == RD_SHIFT ? {cap[DAISY_BITS-2:0], sdi1_in} : cap;
                end
            end
            JOB_HOLD: if (last) begin
                div_d   = '0;
                state_d = WAIT_READY;
            end
            WAIT_READY: begin
                div_d = div;
                if (div != 8'(SCK_DIV)) begin
                    div_d = div + 8'd1;
                end else if (!rdy_sync[1]) begin
                    div_d   = '0;
                    bits_d  = '0;
                    state_d = RD_SETUP;
                end
            end
            RD_HOLD: if (last) begin
                state_d = IDLE;
                res_d   = cap;
                valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (abort_in) begin
            state_d = IDLE;
            div_d   = '0;
            sck_d   = 1'b0;
            res_d   = result_data_out;
            valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state            <= IDLE;
            div              <= '0;
            bits             <= '0;
            sck              <= 1'b0;
            sr               <= '0;
            cap              <= '0;
            rdy_sync         <= 2'b11;
            sck0_out         <= 1'b0;
            sck1_out         <= 1'b0;
            sdo0_out         <= 1'b0;
            cs0_n_out        <= 1'b1;
            cs1_n_out        <= 1'b1;
            busy_out         <= 1'b0;
            job_ready_out    <= 1'b1;
            result_valid_out <= 1'b0;
            result_data_out  <= '0;
        end else begin
            state            <= state_d;
            div              <= div_d;
            bits             <= bits_d;
            sck              <= sck_d;
            sr               <= sr_d;
            cap              <= cap_d;
            rdy_sync         <= {rdy_sync[0], ready_n_in};
            sck0_out         <= sck_d && state_d == JOB_SHIFT;
            sck1_out         <= sck_d && state_d == RD_SHIFT;
            sdo0_out         <= (state_d inside {JOB_SETUP, JOB_SHIFT, JOB_HOLD}) && sr_d[JOB_BITS-1];
            cs0_n_out        <= !(state_d inside {JOB_SETUP, JOB_SHIFT, JOB_HOLD});
            cs1_n_out        <= !(state_d inside {RD_SETUP, RD_SHIFT, RD_HOLD});
            busy_out         <= state_d != IDLE;
            job_ready_out    <= state_d == IDLE && !valid_d;
            result_valid_out <= valid_d;
            result_data_out  <= res_d;
        end
    end
endmodule

// File: tb/tb_shapool_host_link.sv
// tb_shapool_host_link: scoreboard bench for shapool_host_link with a one-register daisy device model.
module tb_shapool_host_link;
    localparam int JB = 8;
    localparam int DB = 8;
    localparam int SD = 2;
    logic clk_in = 1'b0;
    logic reset_n_in = 1'b1;
    logic [JB-1:0] job_data_in = '0;
    logic job_valid_in = 1'b0;
    logic abort_in = 1'b0;
    logic ready_n_in = 1'b1;
    logic sdi1_in;
    logic job_ready_out, sck0_out, sdo0_out, cs0_n_out, sck1_out, sdo1_out, cs1_n_out;
    logic result_valid_out, busy_out;
    logic [DB-1:0] result_data_out;
    int n_cmp = 0;
    int n_err = 0;
    logic exp_bits[$];
    logic [DB-1:0] exp_res[$];
    logic [DB-1:0] dev_val = '0;
    logic [DB-1:0] dev_sr = '0;
    logic prev_sck0 = 1'b0;
    logic prev_sck1 = 1'b0;

    shapool_host_link #(.JOB_BITS(JB), .DAISY_BITS(DB), .SCK_DIV(SD)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .job_data_in(job_data_in),
        .job_valid_in(job_valid_in), .job_ready_out(job_ready_out), .abort_in(abort_in),
        .sck0_out(sck0_out), .sdo0_out(sdo0_out), .cs0_n_out(cs0_n_out),
        .sck1_out(sck1_out), .sdo1_out(sdo1_out), .sdi1_in(sdi1_in), .cs1_n_out(cs1_n_out),
        .ready_n_in(ready_n_in), .result_data_out(result_data_out),
        .result_valid_out(result_valid_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;
    assign sdi1_in = dev_sr[DB-1];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // device: holds its word while deselected, presents next bit after each sck1 fall
    initial forever begin
        @(negedge clk_in);
        if (cs1_n_out) dev_sr = dev_val;
        else if (prev_sck1 && !sck1_out) dev_sr = dev_sr << 1;
        prev_sck1 = sck1_out;
    end

    // scoreboard monitor
    initial forever begin
        @(negedge clk_in);
        if (sck0_out && !prev_sck0) begin
            if (exp_bits.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sdo0_unexpected_edge: got edge expected none");
            end else chk("sdo0_bit", 64'(sdo0_out), 64'(exp_bits.pop_front()));
        end
        prev_sck0 = sck0_out;
        if (result_valid_out) begin
            if (exp_res.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL result_unexpected_pulse: got %0h expected none", result_data_out);
            end else chk("result_data", 64'(result_data_out), 64'(exp_res.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic send_job(input logic [JB-1:0] d, input int glitch_at);
        int cnt;
        for (int i = JB - 1; i >= 0; i--) exp_bits.push_back(d[i]);
        job_data_in = d;
        job_valid_in = 1'b1;
        @(negedge clk_in);
        job_valid_in = 1'b0;
        chk("job_ready_drop", 64'(job_ready_out), 64'd0);
        chk("busy_set", 64'(busy_out), 64'd1);
        cnt = 0;
        while (!cs0_n_out && cnt < 200) begin
            cnt++;
            if (cnt == glitch_at) ready_n_in = 1'b0;
            if (cnt == glitch_at + 1) ready_n_in = 1'b1;
            @(negedge clk_in);
        end
        chk("cs0_low_cycles", 64'(cnt), 64'd36);
    endtask

    task automatic read_back(input logic [DB-1:0] val);
        int lat;
        int k;
        dev_val = val;
        exp_res.push_back(val);
        ready_n_in = 1'b0;
        lat = 0;
        while (cs1_n_out && lat < 20) begin
            @(negedge clk_in);
            lat++;
        end
        chk("cs1_fall_latency", 64'(lat >= 3 && lat <= 4), 64'd1);
        k = 0;
        while (!result_valid_out && k < 300) begin
            @(negedge clk_in);
            k++;
        end
        chk("result_valid_seen", 64'(result_valid_out), 64'd1);
        chk("ready_low_during_pulse", 64'(job_ready_out), 64'd0);
        ready_n_in = 1'b1;
        @(negedge clk_in);
        chk("pulse_single_ready_back", {62'd0, result_valid_out, job_ready_out}, 64'b01);
        chk("cs1_high_after_read", 64'(cs1_n_out), 64'd1);
    endtask

    initial begin
        int k;
        int rises;
        logic p;
        logic act;
        #1 reset_n_in = 1'b0;
        #2;
        chk("reset_outputs", 64'({sck0_out, sck1_out, sdo0_out, sdo1_out, result_valid_out, busy_out,
                                  cs0_n_out, cs1_n_out, job_ready_out}), 64'b000000111);
        chk("reset_result", 64'(result_data_out), 64'd0);
        repeat (2) @(negedge clk_in);
        reset_n_in = 1'b1;
        @(negedge clk_in);

        send_job(8'hA5, 0);
        act = 1'b0;
        repeat (50) begin
            @(negedge clk_in);
            if (sck1_out || !cs1_n_out) act = 1'b1;
        end
        chk("no_read_while_ready_high", 64'(act), 64'd0);
        read_back(8'h3C);

        // abort after the third sck0 rise
        exp_bits.push_back(1'b1); exp_bits.push_back(1'b1); exp_bits.push_back(1'b0);
        job_data_in = 8'hC3;
        job_valid_in = 1'b1;
        @(negedge clk_in);
        job_valid_in = 1'b0;
        rises = 0; k = 0; p = sck0_out;
        while (rises < 3 && k < 200) begin
            @(negedge clk_in);
            k++;
            if (sck0_out && !p) rises++;
            p = sck0_out;
        end
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        chk("abort_state", 64'({cs0_n_out, sck0_out, busy_out, result_valid_out, sdo0_out}), 64'b10000);
        chk("abort_keeps_result", 64'(result_data_out), 64'h3C);
        @(negedge clk_in);
        chk("abort_ready", 64'(job_ready_out), 64'd1);

        // abort wins over a simultaneous job offer
        job_data_in = 8'hFF;
        job_valid_in = 1'b1;
        abort_in = 1'b1;
        @(negedge clk_in);
        job_valid_in = 1'b0;
        abort_in = 1'b0;
        chk("abort_priority", 64'({busy_out, cs0_n_out, job_ready_out}), 64'b011);
        @(negedge clk_in);
        chk("abort_priority_idle", 64'(busy_out), 64'd0);

        // clean job after abort, with a READY glitch inside the guard window
        send_job(8'hFF, 35);
        act = 1'b0;
        repeat (20) begin
            @(negedge clk_in);
            if (sck1_out || !cs1_n_out) act = 1'b1;
        end
        chk("glitch_ignored", 64'(act), 64'd0);
        read_back(8'h81);

        // asynchronous reset during the read phase
        send_job(8'h01, 0);
        dev_val = 8'h96;
        ready_n_in = 1'b0;
        k = 0;
        while (cs1_n_out && k < 100) begin
            @(negedge clk_in);
            k++;
        end
        rises = 0; k = 0; p = sck1_out;
        while (rises < 3 && k < 200) begin
            @(negedge clk_in);
            k++;
            if (sck1_out && !p) rises++;
            p = sck1_out;
        end
        chk("reached_read_phase", 64'(rises), 64'd3);
        reset_n_in = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({sck0_out, sck1_out, sdo0_out, sdo1_out, result_valid_out, busy_out,
                                        cs0_n_out, cs1_n_out, job_ready_out}), 64'b000000111);
        chk("async_reset_result", 64'(result_data_out), 64'd0);
        ready_n_in = 1'b1;
        @(negedge clk_in);
        reset_n_in = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("post_reset_idle", 64'({busy_out, job_ready_out, cs1_n_out, result_valid_out}), 64'b0110);
        chk("post_reset_result", 64'(result_data_out), 64'd0);

        chk("bits_queue_drained", 64'(exp_bits.size()), 64'd0);
        chk("result_queue_drained", 64'(exp_res.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/shapool_host_link.md
Name: shapool_host_link

Overview:
- Host-side controller for one shapool device chain.
- Accepts a job word and shifts it MSB-first over the global SPI-style bus (sck0/sdi0/cs0_n) to all devices.
- Waits for the shared open-drain READY line, then clocks the daisy-chained result back through the sck1/sdi1/sdo1/cs1_n chain and presents it as a parallel word.
- Sits on the controller FPGA, or in a simulation bench, as the counterpart of the device top level.

Parameters:
- JOB_BITS, 352, width of job word shifted on the global bus (256 midstate + 96 message bits).
- DAISY_BITS, 64, total bits read back through the daisy chain (devices × per-device result width).
- SCK_DIV, 4, SCK half-period in clk_in cycles; legal range 2..255.

Ports:
- clk_in  in  1  system clock.
- reset_n_in  in  1  asynchronous active-low reset.
- job_data_in  in  JOB_BITS  job word, MSB shifted first.
- job_valid_in  in  1  job offered.
- job_ready_out  out  1  high only in IDLE; a job transfers when valid && ready.
- abort_in  in  1  synchronous abort to IDLE.
- sck0_out  out  1  global bus clock.
- sdo0_out  out  1  global bus data (to devices' sdi0).
- cs0_n_out  out  1  global bus select, active low.
- sck1_out  out  1  daisy clock.
- sdo1_out  out  1  daisy data into first device; constant 0.
- sdi1_in  in  1  daisy data from last device.
- cs1_n_out  out  1  daisy select, active low.
- ready_n_in  in  1  wired-OR READY from devices (pulled up), asynchronous.
- result_data_out  out  DAISY_BITS  captured chain contents, first bit received at MSB.
- result_valid_out  out  1  one-cycle pulse when result_data_out is updated.
- busy_out  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - sck0_out, sck1_out, sdo0_out, sdo1_out, result_valid_out, busy_out: 0.
  - cs0_n_out, cs1_n_out, job_ready_out: 1.
  - result_data_out: 0.
- ready_n_in passes through a 2-flop synchronizer (reset value 1); only the synchronized value is used.
- SPI mode 0 on both buses:
  - SCK idles low.
  - Host changes data while SCK is low.
  - Devices sample on SCK rising edge.
  - Host samples sdi1_in in the same clk cycle it drives sck1_out high.
- States: IDLE, JOB_SETUP, JOB_SHIFT, JOB_HOLD, WAIT_READY, RD_SETUP, RD_SHIFT, RD_HOLD.
- IDLE:
  - On job_valid_in && job_ready_out, latch job_data_in into the shift register.
  - Drive cs0_n_out low and sdo0_out = bit JOB_BITS-1; go to JOB_SETUP.
- JOB_SETUP: SCK_DIV cycles with SCK low, then JOB_SHIFT.
- JOB_SHIFT, per bit:
  - SCK high for SCK_DIV cycles, then low for SCK_DIV cycles.
  - On the falling transition, shift so the next bit appears on sdo0_out.
  - After JOB_BITS rising edges, go to JOB_HOLD.
- JOB_HOLD: SCK_DIV cycles with SCK low, then cs0_n_out high, sdo0_out 0, go to WAIT_READY.
- Job transfer length: cs0_n_out is low for exactly (2·JOB_BITS+2)·SCK_DIV cycles.
- WAIT_READY:
  - Ignore synchronized ready_n for SCK_DIV cycles after entry (guard).
  - Then on synchronized ready_n == 0, drive cs1_n_out low and go to RD_SETUP.
- RD_SETUP, RD_SHIFT, RD_HOLD: same timing as the job phases, using sck1/cs1_n.
  - Each rising edge shifts sdi1_in into the LSB of the capture register; DAISY_BITS edges total.
- End of RD_HOLD:
  - cs1_n_out high.
  - result_data_out loaded from the capture register.
  - result_valid_out pulses for 1 cycle; return to IDLE.
- job_ready_out rises in the cycle after the pulse.
- abort_in:
  - Valid in any state; next cycle is IDLE.
  - Both cs_n high, both SCK low, sdo0_out 0.
  - result_data_out unchanged, no result_valid_out pulse.
  - abort_in has priority over a simultaneous job_valid_in in IDLE, so no job is accepted.
- job_valid_in outside IDLE is ignored; job_data_in is don't-care after acceptance.
- Reset mid-transfer: outputs return to reset values immediately (asynchronous), giving a clean cs_n rise seen by devices.
- Counters:
  - Bit counter is $clog2(max(JOB_BITS,DAISY_BITS)+1) bits.
  - Divider counter is 8 bits; no wrap-around in either.

Test Plan:
- JOB_BITS=8, DAISY_BITS=8, SCK_DIV=2; offer job 0xA5 -> sdo0_out sampled at 8 sck0 rising edges reads 1,0,1,0,0,1,0,1; cs0_n_out low exactly 36 cycles; job_ready_out low from the next cycle.
- After the job, hold ready_n_in high 50 cycles, then low -> no sck1 activity while high; cs1_n_out falls 3–4 cycles after ready_n_in falls, plus the guard if still in it.
- Device model returns 0x3C on sdi1_in, changing on sck1 falling edges -> result_data_out=0x3C with a single-cycle result_valid_out; job_ready_out=1 the next cycle.
- Assert abort_in after the 3rd sck0 rising edge -> next cycle cs0_n_out=1, sck0_out=0, busy_out=0, no result_valid_out; a new job 0xFF then transfers cleanly.
- Assert reset_n_in low mid read phase -> all outputs go to reset values with no clk edge; after release, result_data_out=0 and the state is IDLE.
- ready_n_in glitch low for 1 cycle during the guard window -> ignored; a steady low after the guard starts the read.
